ring_counter: RTL and testbench
===============================

# ring_counter

Parameterised synchronous ring/Johnson counter with a one-hot (ring) or twisted-ring (Johnson) state register driven straight onto its output. It serves as a sequence and phase generator for downstream strobe/select logic. It is a single-clock block with a synchronous active-low clear that loads a defined seed. Illegal states, such as power-up garbage or upsets, are detected and corrected back into the legal sequence.

## Interface
Parameters:
- WIDTH, default 4: number of state bits; legal range 2..32.
- MODE, default 0: 0 selects the ring counter (one-hot circulate); 1 selects the Johnson counter (inverted-MSB feedback).
- SELF_CORRECT, default 1: 1 forces any illegal state to the seed on the next clock; 0 shifts illegal states blindly.

Ports (positional order is q, clk, clr):
- clk, input, 1 bit: sole clock; all state changes on its rising edge.
- clr, input, 1 bit: reset. One clock; reset is synchronous and active-low: clr=0 sampled at a rising clk edge loads the seed.
- q, output, WIDTH bits: counter state, driven directly from the state register with no combinational path from inputs.

## Operation
- Seed (reset value of q):
  - MODE=0: one followed by zeros, e.g. 4'b0001.
  - MODE=1: all zeros, e.g. 4'b0000.
- Ring mode (MODE=0), clr=1, legal state: rotate left, q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - Sequence for WIDTH=4: 0001 → 0010 → 0100 → 1000 → 0001.
  - Period is WIDTH clocks.
  - A state is legal when exactly one bit is set.
- Johnson mode (MODE=1), clr=1, legal state: q <= {q[WIDTH-2:0], ~q[WIDTH-1]}.
  - Sequence for WIDTH=4: 0000 → 0001 → 0011 → 0111 → 1111 → 1110 → 1100 → 1000 → 0000.
  - Period is 2*WIDTH clocks.
  - A state is legal when the count of adjacent-bit differences (q[i]^q[i+1], i=0..WIDTH-2) is ≤ 1.
- Illegal state with SELF_CORRECT=1: the next state is the seed, regardless of mode. This covers all-zeros and multi-hot in ring mode, and non-contiguous patterns in Johnson mode.
- Illegal state with SELF_CORRECT=0: the normal shift rule applies unchanged.
- X/undriven state before the first clr=0 edge is not required to resolve. The environment must apply clr=0 for at least one rising edge before relying on q.
- Reset has priority over all other behaviour.

## Timing
- Latency is one clock: each rising edge with clr=1 advances q by exactly one step, visible immediately after that edge.
- clr is sampled only at rising edges:
  - A clr=0 pulse that rises and falls between edges has no effect.
  - clr changes between edges do not alter q asynchronously.
- Reset mid-sequence: the first edge with clr=0 loads the seed. q holds the seed for every edge at which clr=0.
- Release: the first edge with clr=1 after reset produces the seed's successor (ring 0010, Johnson 0001).
- Wrap-around is seamless, with no idle or dead cycle: ring 1000 → 0001, Johnson 1000 → 0000.
- Illegal-state correction takes exactly one edge. The legal sequence resumes from the seed on the following edge.

## Test plan
- Ring reset: WIDTH=4, MODE=0, q unknown, clr=0 for one edge → q=0001; hold clr=0 for 3 more edges → q stays 0001.
- Ring circulate: after reset, clr=1 for 8 edges → q = 0010, 0100, 1000, 0001, 0010, 0100, 1000, 0001 (period 4, wrap checked).
- Reset mid-run: ring at q=0100, clr=0 at next edge → q=0001; clr=1 → 0010. A clr=0 glitch between edges leaves q unchanged.
- Johnson sequence: MODE=1, reset → 0000; 9 edges with clr=1 → 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001.
- Self-correction: force state to 0110 (ring) → next edge q=0001; force 0101 (Johnson) → next edge 0000; force 0000 (ring) → next edge 0001.
- Width sweep: WIDTH=2 and WIDTH=8, both modes → periods 2/4 and 8/16 respectively; q always legal after reset.

Source files
------------

// File: rtl/ring_counter.sv
// Parameterised ring (one-hot) / Johnson (twisted-ring) counter used as a
// phase generator; illegal states can optionally be steered back to the seed.
module ring_counter #(
  parameter int WIDTH        = 4,
  parameter int MODE         = 0,
  parameter int SELF_CORRECT = 1
) (
  output logic [WIDTH-1:0] q,
  input  logic             clk,
  input  logic             clr
);

  localparam logic [WIDTH-1:0] SEED = (MODE == 0) ? WIDTH'(1) : '0;

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic [WIDTH-1:0] shifted;
  logic             feedback;
  logic             legal;
  int unsigned      ones;
  int unsigned      edges;

  always_comb begin
    ones  = 0;
    edges = 0;
    for (int i = 0; i < WIDTH; i++)
      ones = ones + int'(state_q[i]);
    for (int i = 0; i < WIDTH - 1; i++)
      edges = edges + int'(state_q[i] ^ state_q[i+1]);
    // Johnson states are a single run of ones against one wall, so at most
    // one interior 0/1 boundary ever exists.
    legal = (MODE == 0) ? (ones == 1) : (edges <= 1);
  end

  always_comb begin
    feedback = (MODE == 0) ? state_q[WIDTH-1] : ~state_q[WIDTH-1];
    shifted  = {state_q[WIDTH-2:0], feedback};
    state_d  = shifted;
    if ((SELF_CORRECT != 0) && !legal)
      state_d = SEED;
  end

  always_ff @(posedge clk) begin
    if (!clr) state_q <= SEED;
    else      state_q <= state_d;
  end

  assign q = state_q;

endmodule

// File: tb/tb_ring_counter.sv
// Scoreboarded bench for ring_counter: six configurations (WIDTH 2/4/8, both
// modes) share clk/clr; expected states are pushed per edge and checked later.
module tb_ring_counter;

  localparam int N = 6;
  localparam int CW [N] = '{4, 4, 2, 2, 8, 8};
  localparam int CM [N] = '{0, 1, 0, 1, 0, 1};

  logic       clk = 0;
  logic       clr = 1;
  logic [3:0] q_r4, q_j4;
  logic [1:0] q_r2, q_j2;
  logic [7:0] q_r8, q_j8;
  logic [31:0] act [N];

  logic [3:0] fr4, fj4;
  logic [7:0] fr8, fj8;

  logic [31:0] exp_q [N][$];
  int idx [N];
  int checks = 0;
  int errors = 0;
  bit stim_done = 0;

  always #5 clk = ~clk;

  ring_counter #(.WIDTH(4), .MODE(0)) dut_r4 (.q(q_r4), .clk(clk), .clr(clr));
  ring_counter #(.WIDTH(4), .MODE(1)) dut_j4 (.q(q_j4), .clk(clk), .clr(clr));
  ring_counter #(.WIDTH(2), .MODE(0)) dut_r2 (.q(q_r2), .clk(clk), .clr(clr));
  ring_counter #(.WIDTH(2), .MODE(1)) dut_j2 (.q(q_j2), .clk(clk), .clr(clr));
  ring_counter #(.WIDTH(8), .MODE(0)) dut_r8 (.q(q_r8), .clk(clk), .clr(clr));
  ring_counter #(.WIDTH(8), .MODE(1)) dut_j8 (.q(q_j8), .clk(clk), .clr(clr));

  assign act[0] = 32'(q_r4);
  assign act[1] = 32'(q_j4);
  assign act[2] = 32'(q_r2);
  assign act[3] = 32'(q_j2);
  assign act[4] = 32'(q_r8);
  assign act[5] = 32'(q_j8);

  // k-th state after the seed, written from the closed form of each sequence
  function automatic logic [31:0] model(input int w, input int m, input int k);
    longint unsigned full, v;
    full = (64'd1 << w) - 1;
    if (m == 0) v = 64'd1 << k;
    else if (k <= w) v = (64'd1 << k) - 1;
    else v = full & ~((64'd1 << (k - w)) - 1);
    return v[31:0];
  endfunction

  // one clock of stimulus; fm selects configurations to corrupt before the edge
  task automatic step(input logic c, input logic [N-1:0] fm, input bit glitch);
    @(negedge clk);
    clr = c;
    if (fm[0]) force dut_r4.state_q = fr4;
    if (fm[1]) force dut_j4.state_q = fj4;
    if (fm[4]) force dut_r8.state_q = fr8;
    if (fm[5]) force dut_j8.state_q = fj8;
    #1;
    if (fm[0]) release dut_r4.state_q;
    if (fm[1]) release dut_j4.state_q;
    if (fm[4]) release dut_r8.state_q;
    if (fm[5]) release dut_j8.state_q;
    if (glitch) begin
      clr = 0;
      #2;
      clr = 1;
    end
    for (int i = 0; i < N; i++) begin
      if (!c || fm[i]) idx[i] = 0;
      else idx[i] = (idx[i] + 1) % ((CM[i] == 0) ? CW[i] : 2 * CW[i]);
      exp_q[i].push_back(model(CW[i], CM[i], idx[i]));
    end
  endtask

  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (exp_q[i].size() > 0) begin
          e = exp_q[i].pop_front();
          checks++;
          if (act[i] !== e) begin
            errors++;
            $display("FAIL cfg%0d(W%0d M%0d) q=%b expected=%b at %0t",
                     i, CW[i], CM[i], act[i], e, $time);
          end
        end
      end
    end
  end

  initial begin : stim
    for (int i = 0; i < N; i++) idx[i] = 0;
    // reset held for four edges
    repeat (4) step(1'b0, '0, 0);
    // circulate through two ring periods and past the Johnson wrap
    repeat (9) step(1'b1, '0, 0);
    // mid-run reset, release, then a clr glitch between edges
    step(1'b0, '0, 0);
    step(1'b1, '0, 0);
    step(1'b1, '0, 1);
    repeat (20) step(1'b1, '0, 0);
    // corrupt states: ring multi-hot, Johnson non-contiguous
    fr4 = 4'b0110; fj4 = 4'b0101; fr8 = 8'b1000_0001; fj8 = 8'b0010_0100;
    step(1'b1, 6'b110011, 0);
    step(1'b1, '0, 0);
    // ring all-zeros is also illegal
    fr4 = 4'b0000; fr8 = 8'b0000_0000; fj4 = 4'b1011; fj8 = 8'b1111_0111;
    step(1'b1, 6'b110011, 0);
    repeat (3) step(1'b1, '0, 0);
    // reset wins over a concurrent illegal state
    fr4 = 4'b1111;
    step(1'b0, 6'b000001, 0);
    step(1'b1, '0, 0);
    repeat (3) @(negedge clk);
    stim_done = 1;
  end

  initial begin : finisher
    wait (stim_done);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin
        errors++;
        $display("FAIL cfg%0d drain: pending=%0d expected=0", i, exp_q[i].size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: bench did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
